aes_round_ctrl: RTL
===================

AES_ROUND_CTRL -- requirements
Module: aes_round_ctrl

Interface
REQ-001 SHALL use the following parameter: NR_W, default 4, width of the round and key-index outputs.
REQ-002 SHALL have ports clk  in  1  sole clock; all state updates on the rising edge.
REQ-003 SHALL have ports rst  in  1  synchronous reset, active-high.
REQ-004 SHALL have ports start  in  1  request to begin one block encryption.
REQ-005 SHALL have ports switch  in  2  key size: 2'b00 gives AES-128 (nr=10), 2'b01 gives AES-192 (nr=12), 2'b10 and 2'b11 give AES-256 (nr=14).
REQ-006 SHALL have ports ready  out  1  high only in IDLE; start is accepted only when ready=1.
REQ-007 SHALL have ports busy  out  1  high in INIT, ROUND and FINAL.
REQ-008 SHALL have ports done  out  1  one-cycle pulse in DONE.
REQ-009 SHALL have ports round  out  NR_W  current round number: 0 in INIT, 1..nr in ROUND/FINAL, 0 elsewhere.
REQ-010 SHALL have ports key_idx  out  NR_W  round-key select, always equal to round.
REQ-011 SHALL have ports load_en  out  1  load the input block into the state register (INIT only).
REQ-012 SHALL have ports sub_en, shift_en, ark_en  out  1 each  SubBytes, ShiftRows and AddRoundKey stage enables.
REQ-013 SHALL have ports mix_en  out  1  MixColumns enable (ROUND only).
REQ-014 SHALL have ports abort  in  1  cancel; present only with AES_ROUND_CTRL_ABORT_EN.

Function
REQ-015 SHALL implement the FSM IDLE -> INIT -> ROUND -> FINAL -> DONE -> IDLE, with one cycle per state visit.
REQ-016 SHALL leave IDLE for INIT only on a rising edge where start=1; with start=0 it SHALL stay in IDLE.
REQ-017 SHALL latch switch on the accepting edge into nr_q; switch changes while busy SHALL be ignored.
REQ-018 SHALL in INIT assert load_en=1, ark_en=1, round=0; next state ROUND with round=1.
REQ-019 SHALL in ROUND assert sub_en=shift_en=mix_en=ark_en=1; round increments each cycle; when round=nr_q-1 the next state is FINAL.
REQ-020 SHALL in FINAL assert sub_en=shift_en=ark_en=1, mix_en=0, round=nr_q; next state DONE.
REQ-021 SHALL in DONE assert done=1 with all enables 0; next state IDLE.
REQ-022 SHALL make all outputs Moore-decoded from the state and round registers, with no combinational path from start/switch to outputs.
REQ-023 SHALL give a latency of nr+2 cycles: done is high in cycle nr+2 after the accepting edge (cycle 1 = INIT).
REQ-024 SHALL provide back-to-back operation: start=1 during DONE is ignored; it is accepted on the following cycle, in IDLE, at the earliest.
REQ-025 SHALL keep the enables mutually consistent: mix_en=1 implies sub_en=shift_en=ark_en=1; load_en=1 only in INIT.
REQ-026 SHALL never let round exceed nr_q and never wrap; it is reset to 0 on exit from DONE.

Reset
REQ-027 SHALL on rst=1 at a clock edge force state IDLE and clear round and nr_q to 0, regardless of the current state, including mid-round.
REQ-028 SHALL hold these output values under reset: ready=1; busy, done, load_en, sub_en, shift_en, mix_en and ark_en=0; round=key_idx=0.
REQ-029 SHALL give rst priority over start and abort on the same edge.

Configuration
REQ-030 SHALL with AES_ROUND_CTRL_ABORT_EN defined make abort=1 in INIT, ROUND or FINAL move the FSM to IDLE on the next edge, with no done pulse and round cleared; abort in IDLE or DONE has no effect.
REQ-031 SHALL with AES_ROUND_CTRL_ABORT_EN undefined omit the abort port and its logic; the behaviour is otherwise identical.

Structure
REQ-032 SHALL place the state enum, the NR_128/192/256 constants (10/12/14) and the key-size decode function in shared package aes_ctrl_pkg.
REQ-033 SHALL be a single module with no sub-modules; the nr decode is a package function.

Verification
REQ-034 SHALL cover: switch=2'b00, start pulse -> round sequence 0..10, mix_en low only at round 10, done in cycle 12.
REQ-035 SHALL cover: switch=2'b01 -> FINAL at round=12, done in cycle 14; switch=2'b11 -> done in cycle 16 (nr=14).
REQ-036 SHALL cover: switch toggled 00->10 during ROUND -> run still completes with nr=10.
REQ-037 SHALL cover: rst=1 at round=5 -> next cycle IDLE, ready=1, all enables 0, no done pulse.
REQ-038 SHALL cover: start held high continuously -> runs separated by exactly one IDLE cycle; start=1 in DONE is not accepted.
REQ-039 SHALL cover, with AES_ROUND_CTRL_ABORT_EN: abort at round=3 -> IDLE next cycle, done never asserted, new start accepted.

Source files
------------

// File: rtl/aes_ctrl_pkg.sv
// Shared definitions for the AES round controller: the state encoding,
// the round count of each key size and the key-size decode.
package aes_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_INIT  = 3'd1,
        ST_ROUND = 3'd2,
        ST_FINAL = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    localparam int NR_128 = 10;
    localparam int NR_192 = 12;
    localparam int NR_256 = 14;

    // Both upper encodings select AES-256.
    function automatic int nr_decode(input logic [1:0] key_size);
        case (key_size)
            2'b00:   return NR_128;
            2'b01:   return NR_192;
            default: return NR_256;
        endcase
    endfunction

endpackage

// File: rtl/aes_round_ctrl.sv
// AES round sequencer: IDLE -> INIT -> ROUND x(nr-1) -> FINAL -> DONE.
// Optional cancel input enabled by defining AES_ROUND_CTRL_ABORT_EN.
module aes_round_ctrl
    import aes_ctrl_pkg::*;
#(
    parameter int NR_W = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [1:0]      switch,
`ifdef AES_ROUND_CTRL_ABORT_EN
    input  logic            abort,
`endif
    output logic            ready,
    output logic            busy,
    output logic            done,
    output logic [NR_W-1:0] round,
    output logic [NR_W-1:0] key_idx,
    output logic            load_en,
    output logic            sub_en,
    output logic            shift_en,
    output logic            ark_en,
    output logic            mix_en
);

    state_e          state_q, state_d;
    logic [NR_W-1:0] round_q, round_d;
    logic [NR_W-1:0] nr_q, nr_d;
    logic            abort_req;

`ifdef AES_ROUND_CTRL_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            round_q <= '0;
            nr_q    <= '0;
        end else begin
            state_q <= state_d;
            round_q <= round_d;
            nr_q    <= nr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        round_d = round_q;
        nr_d    = nr_q;
        case (state_q)
            ST_IDLE: begin
                round_d = '0;
                if (start) begin
                    state_d = ST_INIT;
                    nr_d    = NR_W'(nr_decode(switch));
                end
            end
            ST_INIT: begin
                state_d = ST_ROUND;
                round_d = NR_W'(1);
            end
            ST_ROUND: begin
                round_d = round_q + 1'b1;
                if (round_q == nr_q - 1'b1) begin
                    state_d = ST_FINAL;
                end
            end
            ST_FINAL: state_d = ST_DONE;
            ST_DONE: begin
                state_d = ST_IDLE;
                round_d = '0;
            end
            default: begin
                state_d = ST_IDLE;
                round_d = '0;
            end
        endcase
        // A cancel only matters while a block is in flight.
        if (abort_req && (state_q == ST_INIT || state_q == ST_ROUND || state_q == ST_FINAL)) begin
            state_d = ST_IDLE;
            round_d = '0;
        end
    end

    always_comb begin
        ready    = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        load_en  = 1'b0;
        sub_en   = 1'b0;
        shift_en = 1'b0;
        ark_en   = 1'b0;
        mix_en   = 1'b0;
        round    = '0;
        case (state_q)
            ST_IDLE: ready = 1'b1;
            ST_INIT: begin
                busy    = 1'b1;
                load_en = 1'b1;
                ark_en  = 1'b1;
            end
            ST_ROUND: begin
                busy     = 1'b1;
                sub_en   = 1'b1;
                shift_en = 1'b1;
                mix_en   = 1'b1;
                ark_en   = 1'b1;
                round    = round_q;
            end
            ST_FINAL: begin
                busy     = 1'b1;
                sub_en   = 1'b1;
                shift_en = 1'b1;
                ark_en   = 1'b1;
                round    = round_q;
            end
            ST_DONE: done = 1'b1;
            default: ready = 1'b0;
        endcase
        key_idx = round;
    end

endmodule
